// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit types and constants for the stopwatch controller
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef struct packed {
    digit_t minute;
    digit_t tensec;
    digit_t onesec;
    digit_t tenth;
  } time_t;
  localparam time_t ZERO_TIME = '0;
  typedef enum logic [2:0] {IDLE, RUN, STOP, LAP, DONE} state_t;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: link between the stopwatch controller (master) and the BCD counter (slave)
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;
  digit_t cnt_minute, cnt_tensec, cnt_onesec, cnt_tenth;
  logic cnt_cascade, cnt_enable, cnt_up, cnt_clear;
  modport master (
    input  cnt_minute, cnt_tensec, cnt_onesec, cnt_tenth, cnt_cascade,
    output cnt_enable, cnt_up, cnt_clear
  );
  modport slave (
    output cnt_minute, cnt_tensec, cnt_onesec, cnt_tenth, cnt_cascade,
    input  cnt_enable, cnt_up, cnt_clear
  );
endinterface

// File: rtl/sw_button_cond.sv
// sw_button_cond: synchronize, optionally debounce (STOPWATCH_DEBOUNCE_EN) and edge-detect one button into a press pulse
module sw_button_cond #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic [1:0] sync;
  logic level, level_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], btn};
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] stable;
  // accept the synchronized level only after it has differed from the accepted one for DEBOUNCE_CYC cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stable <= '0;
      level  <= 1'b0;
    end else if (sync[1] == level) stable <= '0;
    else if (stable == CW'(DEBOUNCE_CYC - 1)) begin
      stable <= '0;
      level  <= sync[1];
    end else stable <= stable + CW'(1);
`else
  assign level = sync[1] & (DEBOUNCE_CYC >= 1);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/lap/count-down sequencing for a BCD stopwatch counter.
// Define STOPWATCH_DEBOUNCE_EN to enable full button debounce.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV     = 5000000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   btn_start,
  input  logic   btn_lap,
  input  logic   btn_dir,
  stopwatch_ctrl_if.master cnt,
  output digit_t disp_minute,
  output digit_t disp_tensec,
  output digit_t disp_onesec,
  output digit_t disp_tenth,
  output logic   running,
  output logic   lap_active,
  output logic   alarm,
  output logic   ovf
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state, nxt;
  logic [PW-1:0] presc;
  time_t live, lap_q;
  logic p_start, p_lap, p_dir, zero_down, latch, tog, clr_nxt, clr_q, up_q, en_q;
  sw_button_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (.clk(clk), .reset(reset), .btn(btn_start), .press(p_start));
  sw_button_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lap   (.clk(clk), .reset(reset), .btn(btn_lap),   .press(p_lap));
  sw_button_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dir   (.clk(clk), .reset(reset), .btn(btn_dir),   .press(p_dir));
  assign live = {cnt.cnt_minute, cnt.cnt_tensec, cnt.cnt_onesec, cnt.cnt_tenth};
  assign running = state inside {RUN, LAP};
  assign lap_active = state == LAP;
  assign alarm = state == DONE;
  assign zero_down = !up_q && live == ZERO_TIME;
  assign latch = state == RUN && nxt == LAP;
  assign cnt.cnt_enable = running && presc == PW'(TICK_DIV - 1);
  assign cnt.cnt_up = up_q;
  assign cnt.cnt_clear = clr_q;
  assign {disp_minute, disp_tensec, disp_onesec, disp_tenth} = lap_active ? lap_q : live;
  // reaching zero while counting down wins so the counter never borrows past 0.0.0.0
  always_comb begin
    nxt = state;
    tog = 1'b0;
    clr_nxt = 1'b0;
    case (state)
      IDLE: begin
        nxt = p_start ? (up_q ? RUN : DONE) : IDLE;
        tog = p_dir;
      end
      RUN:  nxt = zero_down ? DONE : p_start ? STOP : p_lap ? LAP : RUN;
      LAP:  nxt = zero_down ? DONE : p_start ? STOP : p_lap ? RUN : LAP;
      STOP: begin
        nxt = p_start ? RUN : p_lap ? IDLE : STOP;
        clr_nxt = !p_start && p_lap;
        tog = p_dir;
      end
      DONE: begin
        nxt = (p_start || p_lap) ? IDLE : DONE;
        clr_nxt = p_start || p_lap;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      up_q  <= 1'b1;
      clr_q <= 1'b0;
      en_q  <= 1'b0;
      lap_q <= ZERO_TIME;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      up_q  <= up_q ^ tog;
      clr_q <= clr_nxt;
      en_q  <= cnt.cnt_enable;
      presc <= (clr_q || cnt.cnt_enable) ? '0 : running ? presc + PW'(1) : presc;
      if (latch) lap_q <= live;
      ovf <= clr_q ? 1'b0 : ovf | (en_q & cnt.cnt_cascade & up_q);
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed table plus hand sequences against a behavioural BCD counter model
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DB = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif
  typedef struct {
    string name;
    logic [2:0] btn;
    logic [4:0] exp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, btn_start = 1'b0, btn_lap = 1'b0, btn_dir = 1'b0;
  logic [3:0] dm, dts, dos, dtn;
  logic running, lap_active, alarm, ovf;
  logic [15:0] t, ld_val, disp;
  logic ld = 1'b0, casc = 1'b0;
  int npass = 0, ntot = 0;
  vec_t tbl[16];
  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DB)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap), .btn_dir(btn_dir),
    .cnt(sw), .disp_minute(dm), .disp_tensec(dts), .disp_onesec(dos), .disp_tenth(dtn),
    .running(running), .lap_active(lap_active), .alarm(alarm), .ovf(ovf)
  );
  always #5 clk = ~clk;
  assign disp = {dm, dts, dos, dtn};
  assign {sw.cnt_minute, sw.cnt_tensec, sw.cnt_onesec, sw.cnt_tenth} = t;
  assign sw.cnt_cascade = casc;
  function automatic logic [16:0] step(input logic [15:0] v, input logic up);
    int n;
    logic c;
    n = int'(v[15:12]) * 600 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    c = up ? (n == 5999) : (n == 0);
    n = up ? (n + 1) % 6000 : (n == 0 ? 5999 : n - 1);
    return {c, 4'(n / 600), 4'((n % 600) / 100), 4'((n % 100) / 10), 4'(n % 10)};
  endfunction
  always @(posedge clk) begin
    casc <= 1'b0;
    if (ld) t <= ld_val;
    else if (sw.cnt_clear) t <= '0;
    else if (sw.cnt_enable) {casc, t} <= step(t, sw.cnt_up);
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [2:0] b);
    {btn_start, btn_lap, btn_dir} = b;
    cyc(LAT + 3);
    {btn_start, btn_lap, btn_dir} = 3'b000;
    cyc(LAT + 3);
  endtask
  task automatic load(input logic [15:0] v);
    ld_val = v;
    ld = 1'b1;
    cyc(1);
    ld = 1'b0;
  endtask
  initial begin
    int first, n_en, z, a, mism;
    tbl[0]  = '{"start_idle",      3'b100, 5'b10010};
    tbl[1]  = '{"lap_in_run",      3'b010, 5'b11010};
    tbl[2]  = '{"lap_in_lap",      3'b010, 5'b10010};
    tbl[3]  = '{"dir_in_run",      3'b001, 5'b10010};
    tbl[4]  = '{"start_lap_run",   3'b110, 5'b00010};
    tbl[5]  = '{"dir_in_stop",     3'b001, 5'b00000};
    tbl[6]  = '{"dir_in_stop2",    3'b001, 5'b00010};
    tbl[7]  = '{"start_in_stop",   3'b100, 5'b10010};
    tbl[8]  = '{"lap_in_run2",     3'b010, 5'b11010};
    tbl[9]  = '{"start_in_lap",    3'b100, 5'b00010};
    tbl[10] = '{"lap_in_stop",     3'b010, 5'b00011};
    tbl[11] = '{"lap_in_idle",     3'b010, 5'b00011};
    tbl[12] = '{"dir_in_idle",     3'b001, 5'b00001};
    tbl[13] = '{"start_idle_down", 3'b100, 5'b00101};
    tbl[14] = '{"start_in_done",   3'b100, 5'b00001};
    tbl[15] = '{"dir_in_idle2",    3'b001, 5'b00011};
    ld_val = '0;
    ld = 1'b1;
    cyc(2);
    chk("rst_running", running, 0);
    chk("rst_lap_active", lap_active, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt_up", sw.cnt_up, 1);
    chk("rst_cnt_enable", sw.cnt_enable, 0);
    chk("rst_cnt_clear", sw.cnt_clear, 0);
    ld = 1'b0;
    reset = 1'b0;
    cyc(2);
    // enable cadence from a fresh prescaler, then silence after stop
    btn_start = 1'b1;
    for (int i = 0; i < 20 && !running; i++) cyc(1);
    chk("run_entered", running, 1);
    btn_start = 1'b0;
    first = -1;
    n_en = 0;
    for (int k = 0; k < 16; k++) begin
      if (sw.cnt_enable) begin
        n_en++;
        if (first < 0) first = k;
      end
      cyc(1);
    end
    chk("first_enable_offset", 16'(first), 3);
    chk("enables_in_16", 16'(n_en), 4);
    chk("disp_after_4_ticks", disp, 16'h0004);
    press(3'b100);
    chk("stop_running", running, 0);
    n_en = 0;
    for (int k = 0; k < 12; k++) begin
      if (sw.cnt_enable) n_en++;
      cyc(1);
    end
    chk("no_enable_in_stop", 16'(n_en), 0);
    // lap freeze with the counter held at 0.01.2 until the latch
    press(3'b100);
    ld_val = 16'h0012;
    ld = 1'b1;
    btn_lap = 1'b1;
    for (int i = 0; i < 20 && !lap_active; i++) cyc(1);
    ld = 1'b0;
    btn_lap = 1'b0;
    chk("lap_entered", lap_active, 1);
    chk("lap_latched", disp, 16'h0012);
    cyc(LAT + 15);
    chk("lap_frozen", disp, 16'h0012);
    chk("lap_still_running", running, 1);
    chk("counter_moves_in_lap", t == 16'h0012, 0);
    press(3'b010);
    chk("lap_exit", lap_active, 0);
    mism = 0;
    for (int k = 0; k < 8; k++) begin
      if (disp !== t) mism++;
      cyc(1);
    end
    chk("disp_live_after_lap", 16'(mism), 0);
    // count down from 0.00.3 into DONE
    press(3'b100);
    chk("stop_before_down", running, 0);
    load(16'h0003);
    press(3'b001);
    chk("dir_toggle_stop", sw.cnt_up, 0);
    btn_start = 1'b1;
    z = -1;
    a = -1;
    for (int i = 0; i < 80 && a < 0; i++) begin
      if (i == LAT + 3) btn_start = 1'b0;
      if (z < 0 && t == 16'h0000) z = i;
      if (alarm) a = i;
      else cyc(1);
    end
    btn_start = 1'b0;
    chk("done_cycle_after_zero", 16'(a), 16'(z + 1));
    chk("done_not_running", running, 0);
    chk("no_borrow", t, 16'h0000);
    cyc(LAT + 8);
    chk("done_alarm_held", alarm, 1);
    chk("done_halted", t, 16'h0000);
    btn_lap = 1'b1;
    for (int i = 0; i < 20 && !sw.cnt_clear; i++) cyc(1);
    chk("done_clear_pulse", sw.cnt_clear, 1);
    chk("done_to_idle_alarm", alarm, 0);
    chk("done_to_idle_running", running, 0);
    cyc(1);
    chk("clear_one_cycle", sw.cnt_clear, 0);
    btn_lap = 1'b0;
    cyc(LAT + 3);
    // up-count wrap sets the sticky overflow
    press(3'b001);
    chk("dir_toggle_idle", sw.cnt_up, 1);
    load(16'h9598);
    chk("ovf_before_wrap", ovf, 0);
    btn_start = 1'b1;
    for (int i = 0; i < 60 && !ovf; i++) begin
      if (i == LAT + 3) btn_start = 1'b0;
      cyc(1);
    end
    btn_start = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_counting_continues", running, 1);
    cyc(16);
    chk("ovf_sticky_run", ovf, 1);
    press(3'b100);
    chk("ovf_sticky_stop", ovf, 1);
    press(3'b010);
    chk("ovf_cleared", ovf, 0);
    chk("clear_zeroes_counter", disp, 16'h0000);
    // asynchronous reset in the middle of a down-counting lap
    press(3'b100);
    press(3'b100);
    press(3'b001);
    load(16'h0100);
    press(3'b100);
    press(3'b010);
    chk("pre_reset_lap", lap_active, 1);
    chk("pre_reset_down", sw.cnt_up, 0);
    reset = 1'b1;
    #1;
    chk("arst_running", running, 0);
    chk("arst_lap_active", lap_active, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_cnt_up", sw.cnt_up, 1);
    chk("arst_cnt_enable", sw.cnt_enable, 0);
    chk("arst_cnt_clear", sw.cnt_clear, 0);
    chk("arst_disp_live", disp, t);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    load(16'h0000);
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].btn);
      chk({tbl[i].name, ".running"}, running, tbl[i].exp[4]);
      chk({tbl[i].name, ".lap_active"}, lap_active, tbl[i].exp[3]);
      chk({tbl[i].name, ".alarm"}, alarm, tbl[i].exp[2]);
      chk({tbl[i].name, ".cnt_up"}, sw.cnt_up, tbl[i].exp[1]);
      chk({tbl[i].name, ".disp_zero"}, disp == 16'h0000, tbl[i].exp[0]);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
